// File: rtl/bbox_if.sv
// Pixel-stream and box-result bundle for bbox_tracker.
// master drives the pixel stream and reads results; slave is the tracker.
interface bbox_if #(
    parameter int unsigned XW   = 11,
    parameter int unsigned YW   = 11,
    parameter int unsigned CH   = 4,
    parameter int unsigned CNTW = 22
) ();
    logic                         vs_in;
    logic                         de_in;
    logic [XW-1:0]                x_in;
    logic [YW-1:0]                y_in;
    logic [CH-1:0]                mask_in;
    logic [CNTW-1:0]              min_pix_in;
    logic [CH*(2*YW+2*XW)-1:0]    win_out;
    logic [CH*CNTW-1:0]           pix_cnt_out;
    logic [CH-1:0]                obj_valid;
    logic                         frame_done;

    modport master (
        output vs_in, de_in, x_in, y_in, mask_in, min_pix_in,
        input  win_out, pix_cnt_out, obj_valid, frame_done
    );

    modport slave (
        input  vs_in, de_in, x_in, y_in, mask_in, min_pix_in,
        output win_out, pix_cnt_out, obj_valid, frame_done
    );
endinterface

// File: rtl/bbox_tracker.sv
// Per-channel bounding box / pixel-count tracker over one video frame.
// Results of frame k are published one clock after the vsync rising edge ending it.
module bbox_tracker #(
    parameter int unsigned XW   = 11,
    parameter int unsigned YW   = 11,
    parameter int unsigned CH   = 4,
    parameter int unsigned CNTW = 22
) (
    input logic   clk,
    input logic   rst_n,
    bbox_if.slave bus
);
    localparam int unsigned SW = 2 * YW + 2 * XW;
    localparam logic [CNTW-1:0] CntOne = CNTW'(1);
    localparam logic [CNTW-1:0] CntMax = '1;

    logic          vs_q;
    logic          primed_q, primed_d;
    logic          pend_q, pend_d;
    logic          bnd;
    logic [CH-1:0] hit;

    logic [XW-1:0]   x_min_q [CH];
    logic [XW-1:0]   x_min_d [CH];
    logic [XW-1:0]   x_max_q [CH];
    logic [XW-1:0]   x_max_d [CH];
    logic [YW-1:0]   y_min_q [CH];
    logic [YW-1:0]   y_min_d [CH];
    logic [YW-1:0]   y_max_q [CH];
    logic [YW-1:0]   y_max_d [CH];
    logic [CNTW-1:0] cnt_q   [CH];
    logic [CNTW-1:0] cnt_d   [CH];

    // Frame result captured on the boundary, copied to the outputs one clock later.
    logic [CH*SW-1:0]   snap_win_q, snap_win_d;
    logic [CH*CNTW-1:0] snap_cnt_q, snap_cnt_d;
    logic [CH-1:0]      snap_obj_q, snap_obj_d;

    logic [CH*SW-1:0]   win_q, win_d;
    logic [CH*CNTW-1:0] cnt_out_q, cnt_out_d;
    logic [CH-1:0]      obj_q, obj_d;
    logic               done_q;

    assign bnd = bus.vs_in & ~vs_q;
    assign hit = {CH{bus.de_in}} & bus.mask_in;

    always_comb begin
        primed_d   = primed_q | bnd;
        pend_d     = bnd & primed_q;
        snap_win_d = snap_win_q;
        snap_cnt_d = snap_cnt_q;
        snap_obj_d = snap_obj_q;

        for (int c = 0; c < CH; c++) begin
            x_min_d[c] = x_min_q[c];
            x_max_d[c] = x_max_q[c];
            y_min_d[c] = y_min_q[c];
            y_max_d[c] = y_max_q[c];
            cnt_d[c]   = cnt_q[c];

            if (bnd) begin
                snap_win_d[c*SW +: SW] = (cnt_q[c] != '0) ?
                    {y_min_q[c], y_max_q[c], x_min_q[c], x_max_q[c]} : '0;
                snap_cnt_d[c*CNTW +: CNTW] = cnt_q[c];
                snap_obj_d[c] = (cnt_q[c] != '0) && (cnt_q[c] >= bus.min_pix_in);
                // A pixel on the boundary cycle opens the new frame.
                if (hit[c]) begin
                    x_min_d[c] = bus.x_in;
                    x_max_d[c] = bus.x_in;
                    y_min_d[c] = bus.y_in;
                    y_max_d[c] = bus.y_in;
                    cnt_d[c]   = CntOne;
                end else begin
                    x_min_d[c] = '1;
                    x_max_d[c] = '0;
                    y_min_d[c] = '1;
                    y_max_d[c] = '0;
                    cnt_d[c]   = '0;
                end
            end else if (hit[c]) begin
                if (bus.x_in < x_min_q[c]) x_min_d[c] = bus.x_in;
                if (bus.x_in > x_max_q[c]) x_max_d[c] = bus.x_in;
                if (bus.y_in < y_min_q[c]) y_min_d[c] = bus.y_in;
                if (bus.y_in > y_max_q[c]) y_max_d[c] = bus.y_in;
                if (cnt_q[c] != CntMax) cnt_d[c] = cnt_q[c] + CntOne;
            end
        end

        win_d     = pend_q ? snap_win_q : win_q;
        cnt_out_d = pend_q ? snap_cnt_q : cnt_out_q;
        obj_d     = pend_q ? snap_obj_q : obj_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b1;
            primed_q   <= 1'b0;
            pend_q     <= 1'b0;
            snap_win_q <= '0;
            snap_cnt_q <= '0;
            snap_obj_q <= '0;
            win_q      <= '0;
            cnt_out_q  <= '0;
            obj_q      <= '0;
            done_q     <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                x_min_q[c] <= '1;
                x_max_q[c] <= '0;
                y_min_q[c] <= '1;
                y_max_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            vs_q       <= bus.vs_in;
            primed_q   <= primed_d;
            pend_q     <= pend_d;
            snap_win_q <= snap_win_d;
            snap_cnt_q <= snap_cnt_d;
            snap_obj_q <= snap_obj_d;
            win_q      <= win_d;
            cnt_out_q  <= cnt_out_d;
            obj_q      <= obj_d;
            done_q     <= pend_q;
            for (int c = 0; c < CH; c++) begin
                x_min_q[c] <= x_min_d[c];
                x_max_q[c] <= x_max_d[c];
                y_min_q[c] <= y_min_d[c];
                y_max_q[c] <= y_max_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    assign bus.win_out     = win_q;
    assign bus.pix_cnt_out = cnt_out_q;
    assign bus.obj_valid   = obj_q;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed + randomized bench for bbox_tracker; a frame-level queue model predicts each publish.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_bbox_tracker;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int CH = 4;
    localparam int SW = 2 * YW + 2 * XW;
    localparam int WW = CH * SW;

    typedef struct packed {
        logic [1:0]  c;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    logic clk;
    logic rst_n;

    bbox_if #(.XW(XW), .YW(YW), .CH(CH), .CNTW(22)) bus ();
    bbox_if #(.XW(XW), .YW(YW), .CH(CH), .CNTW(4))  bus_s ();

    assign bus_s.vs_in      = bus.vs_in;
    assign bus_s.de_in      = bus.de_in;
    assign bus_s.x_in       = bus.x_in;
    assign bus_s.y_in       = bus.y_in;
    assign bus_s.mask_in    = bus.mask_in;
    assign bus_s.min_pix_in = bus.min_pix_in[3:0];

    bbox_tracker #(.XW(XW), .YW(YW), .CH(CH), .CNTW(22)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bbox_tracker #(.XW(XW), .YW(YW), .CH(CH), .CNTW(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pixels of the frame in progress, and the currently expected outputs.
    pix_t            fq[$];
    logic            m_primed;
    logic [WW-1:0]   exp_win;
    logic [CH*22-1:0] exp_cnt;
    logic [CH*4-1:0] exp_cnt_s;
    logic [CH-1:0]   exp_obj;
    logic            exp_done;
    int              n_checks;
    int              n_errors;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        fq.delete();
        m_primed  = 1'b0;
        exp_win   = '0;
        exp_cnt   = '0;
        exp_cnt_s = '0;
        exp_obj   = '0;
        exp_done  = 1'b0;
    endtask

    task automatic push_pix(input logic [3:0] mask, input int x, input int y);
        pix_t p;
        for (int c = 0; c < CH; c++) begin
            if (mask[c]) begin
                p.c = c[1:0];
                p.x = x[10:0];
                p.y = y[10:0];
                fq.push_back(p);
            end
        end
    endtask

    task automatic m_publish(input int min_pix);
        for (int c = 0; c < CH; c++) begin
            int n;
            int xmn;
            int xmx;
            int ymn;
            int ymx;
            n = 0; xmn = 2047; xmx = 0; ymn = 2047; ymx = 0;
            foreach (fq[i]) begin
                if (int'(fq[i].c) == c) begin
                    n++;
                    if (int'(fq[i].x) < xmn) xmn = int'(fq[i].x);
                    if (int'(fq[i].x) > xmx) xmx = int'(fq[i].x);
                    if (int'(fq[i].y) < ymn) ymn = int'(fq[i].y);
                    if (int'(fq[i].y) > ymx) ymx = int'(fq[i].y);
                end
            end
            if (m_primed) begin
                exp_win[c*SW +: SW]  = (n > 0) ? {ymn[10:0], ymx[10:0], xmn[10:0], xmx[10:0]} : '0;
                exp_cnt[c*22 +: 22]  = n[21:0];
                exp_cnt_s[c*4 +: 4]  = (n > 15) ? 4'd15 : n[3:0];
                exp_obj[c]           = (n > 0) && (n >= min_pix);
            end
        end
        exp_done = m_primed;
        m_primed = 1'b1;
        fq.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_win"}, bus.win_out, exp_win);
        check({tag, "_cnt"}, bus.pix_cnt_out, exp_cnt);
        check({tag, "_obj"}, bus.obj_valid, exp_obj);
        check({tag, "_win_s"}, bus_s.win_out, exp_win);
        check({tag, "_cnt_s"}, bus_s.pix_cnt_out, exp_cnt_s);
    endtask

    // One pixel-stream cycle inside a frame; min_pix_in is scrambled to show it is ignored here.
    task automatic send(input logic de, input logic [3:0] mask, input int x, input int y);
        bus.vs_in      = 1'b0;
        bus.de_in      = de;
        bus.mask_in    = mask;
        bus.x_in       = x[10:0];
        bus.y_in       = y[10:0];
        bus.min_pix_in = 22'($urandom_range(0, 50));
        if (de) push_pix(mask, x, y);
        tick();
        check("done_idle", bus.frame_done, 1'b0);
        check_outputs("hold");
    endtask

    task automatic boundary(input int min_pix, input logic bde, input logic [3:0] bmask,
                            input int bx, input int by);
        bus.vs_in      = 1'b1;
        bus.de_in      = bde;
        bus.mask_in    = bmask;
        bus.x_in       = bx[10:0];
        bus.y_in       = by[10:0];
        bus.min_pix_in = min_pix[21:0];
        tick();
        check("done_early", bus.frame_done, 1'b0);
        m_publish(min_pix);
        if (bde) push_pix(bmask, bx, by);
        bus.vs_in      = 1'b0;
        bus.de_in      = 1'b0;
        bus.min_pix_in = 22'($urandom_range(0, 50));
        tick();
        check("done_strobe", bus.frame_done, exp_done);
        check("done_strobe_s", bus_s.frame_done, exp_done);
        check_outputs("publish");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_reset();
        rst_n          = 1'b0;
        bus.vs_in      = 1'b1;
        bus.de_in      = 1'b0;
        bus.mask_in    = '0;
        bus.x_in       = '0;
        bus.y_in       = '0;
        bus.min_pix_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_win", bus.win_out, '0);
        check("rst_cnt", bus.pix_cnt_out, '0);
        check("rst_obj", bus.obj_valid, '0);
        check("rst_done", bus.frame_done, 1'b0);
        // vs_in still high at reset release must not count as an edge.
        rst_n = 1'b1;
        tick();
        tick();
        check("no_edge_at_release", bus.frame_done, 1'b0);

        // Primed frame: the first boundary is suppressed.
        send(1'b1, 4'b0001, 10, 20);
        send(1'b1, 4'b0001, 100, 5);
        send(1'b1, 4'b0001, 50, 300);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t1_first_suppressed", bus.frame_done, 1'b0);
        send(1'b1, 4'b0001, 10, 20);
        send(1'b1, 4'b0001, 100, 5);
        send(1'b1, 4'b0001, 50, 300);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t1_done", bus.frame_done, 1'b1);
        check("t1_slice0", bus.win_out[SW-1:0], {11'd5, 11'd300, 11'd10, 11'd100});
        check("t1_cnt0", bus.pix_cnt_out[21:0], 22'd3);

        // Single pixel updates both min and max of both axes.
        send(1'b1, 4'b0001, 7, 9);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t2_slice0", bus.win_out[SW-1:0], {11'd9, 11'd9, 11'd7, 11'd7});

        // Empty channel and threshold.
        for (int i = 0; i < 4; i++) send(1'b1, 4'b0100, 200 + i, 400 - i);
        boundary(5, 1'b0, 4'b0000, 0, 0);
        check("t3_ch1_box", bus.win_out[2*SW-1:SW], '0);
        check("t3_ch1_obj", bus.obj_valid[1], 1'b0);
        check("t3_ch2_obj_lo", bus.obj_valid[2], 1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, 4'b0100, 200 + i, 400 - i);
        boundary(4, 1'b0, 4'b0000, 0, 0);
        check("t3_ch2_obj_hi", bus.obj_valid[2], 1'b1);
        check("t3_ch2_cnt", bus.pix_cnt_out[3*22-1:2*22], 22'd4);

        // Boundary pixel belongs to the next frame.
        send(1'b1, 4'b0001, 20, 30);
        send(1'b1, 4'b0001, 40, 50);
        boundary(1, 1'b1, 4'b0001, 3, 3);
        check("t4_excl_slice0", bus.win_out[SW-1:0], {11'd30, 11'd50, 11'd20, 11'd40});
        check("t4_excl_cnt0", bus.pix_cnt_out[21:0], 22'd2);
        send(1'b1, 4'b0001, 8, 8);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t4_incl_slice0", bus.win_out[SW-1:0], {11'd3, 11'd8, 11'd3, 11'd8});
        check("t4_incl_cnt0", bus.pix_cnt_out[21:0], 22'd2);

        // Saturation on the 4-bit counter instance.
        for (int i = 0; i < 20; i++) send(1'b1, 4'b1000, i, 2 * i);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t5_sat_cnt3", bus_s.pix_cnt_out[15:12], 4'd15);
        check("t5_wide_cnt3", bus.pix_cnt_out[4*22-1:3*22], 22'd20);

        // Randomized frames, including idle cycles and boundary pixels.
        for (int f = 0; f < 6; f++) begin
            int npix;
            npix = int'($urandom_range(5, 30));
            for (int i = 0; i < npix; i++) begin
                send(($urandom % 4) != 0, 4'($urandom % 16),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            end
            boundary(int'($urandom_range(0, 12)), 1'($urandom % 2), 4'($urandom % 16),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        end

        // Back-to-back boundaries; the trailing ones publish empty frames.
        for (int k = 0; k < 3; k++) boundary(0, 1'b0, 4'b0000, 0, 0);
        check("t7_empty_win", bus.win_out, '0);

        // Mid-frame asynchronous reset.
        send(1'b1, 4'b0011, 500, 600);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        send(1'b1, 4'b0010, 11, 12);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_async_win", bus.win_out, '0);
        check("t8_async_cnt", bus.pix_cnt_out, '0);
        check("t8_async_obj", bus.obj_valid, '0);
        check("t8_async_done", bus.frame_done, 1'b0);
        m_reset();
        bus.de_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        send(1'b1, 4'b0001, 1, 2);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t8_suppressed", bus.frame_done, 1'b0);
        send(1'b1, 4'b0001, 33, 44);
        boundary(1, 1'b0, 4'b0000, 0, 0);
        check("t8_slice0", bus.win_out[SW-1:0], {11'd44, 11'd44, 11'd33, 11'd33});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
